// File: rtl/ofdm_bit_source.sv
// Serial bit source for the OFDM transmitter: repeating pattern, PRBS, zero or alternating bits in framed bursts.
// Define ERR_INJECT_EN to add err_inject_i / err_cnt_o single-bit error injection.
module ofdm_bit_source #(
  parameter int                PAT_W     = 4,
  parameter int                LFSR_W    = 7,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 7'h60,
  parameter int                FRAME_LEN = 64,
  parameter int                GAP_LEN   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [PAT_W-1:0]  pattern_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic              bit_out_o,
  output logic              bit_valid_o,
  input  logic              bit_ready_i,
  output logic              sof_o,
  output logic              eof_o,
  output logic [15:0]       frame_cnt_o,
  output logic              busy_o
`ifdef ERR_INJECT_EN
  ,
  input  logic              err_inject_i,
  output logic [15:0]       err_cnt_o
`endif
);

  localparam int PIDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int BIDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GCNT_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(PAT_W - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(FRAME_LEN - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              alt_q, alt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic run;
  logic last;
  logic raw_bit;
  logic flip;

  assign run  = (state_q == ST_RUN);
  assign last = (bidx_q == BIDX_LAST);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    lfsr_d      = lfsr_q;
    pidx_d      = pidx_q;
    bidx_d      = bidx_q;
    gcnt_d      = gcnt_q;
    alt_d       = alt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d   = ST_RUN;
          mode_d    = mode_i;
          pattern_d = pattern_i;
          lfsr_d    = (seed_i == '0) ? '1 : seed_i;
          pidx_d    = '0;
          bidx_d    = '0;
          alt_d     = 1'b0;
        end
      end
      ST_RUN: begin
        if (bit_ready_i) begin
          pidx_d = (pidx_q == PIDX_LAST) ? '0 : pidx_q + 1'b1;
          lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
          alt_d  = ~alt_q;
          bidx_d = bidx_q + 1'b1;
          if (last) begin
            bidx_d      = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (GAP_LEN > 0) begin
              state_d = ST_GAP;
              gcnt_d  = '0;
            end else if (enable_i) begin
              // back-to-back: new config, but LFSR and pattern index keep running
              mode_d    = mode_i;
              pattern_d = pattern_i;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == GCNT_LAST) begin
          if (enable_i) begin
            state_d   = ST_RUN;
            mode_d    = mode_i;
            pattern_d = pattern_i;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      pattern_q   <= '0;
      lfsr_q      <= '0;
      pidx_q      <= '0;
      bidx_q      <= '0;
      gcnt_q      <= '0;
      alt_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      lfsr_q      <= lfsr_d;
      pidx_q      <= pidx_d;
      bidx_q      <= bidx_d;
      gcnt_q      <= gcnt_d;
      alt_q       <= alt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    raw_bit = 1'b0;
    case (mode_q)
      2'b00:   raw_bit = pattern_q[pidx_q];
      2'b01:   raw_bit = lfsr_q[LFSR_W-1];
      2'b11:   raw_bit = alt_q;
      default: raw_bit = 1'b0;
    endcase
  end

`ifdef ERR_INJECT_EN
  // flip_q marks the bit currently presented; a pulse arriving while a bit is
  // stalled waits in pend_q so the held bit never changes under backpressure.
  logic        flip_q, flip_d;
  logic        pend_q, pend_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    flip_d    = flip_q;
    pend_d    = pend_q;
    err_cnt_d = err_cnt_q;
    if (run && !bit_ready_i) begin
      pend_d = pend_q | (err_inject_i & ~flip_q);
    end else if (run) begin
      flip_d = pend_q | err_inject_i;
      pend_d = 1'b0;
      if (flip_q) err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      flip_d = flip_q | pend_q | err_inject_i;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flip_q    <= 1'b0;
      pend_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      flip_q    <= flip_d;
      pend_q    <= pend_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign flip      = flip_q;
  assign err_cnt_o = err_cnt_q;
`else
  assign flip = 1'b0;
`endif

  assign bit_valid_o = run;
  assign bit_out_o   = run & (raw_bit ^ flip);
  assign sof_o       = run && (bidx_q == '0);
  assign eof_o       = run && last;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_GAP);

endmodule

// File: tb/tb_ofdm_bit_source.sv
// Scoreboard bench for ofdm_bit_source: dut_a (8-bit frames, no gap) is scoreboarded,
// dut_b (8-bit frames, 2-cycle gap) has its inter-frame gaps measured.
module tb_ofdm_bit_source;
  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  pattern = 4'b0000;
  logic [6:0]  seed = 7'h00;
  logic        ready = 1'b1;

  logic        a_bit, a_valid, a_sof, a_eof, a_busy;
  logic [15:0] a_fc;
  logic        b_bit, b_valid, b_sof, b_eof, b_busy;
  logic [15:0] b_fc;
`ifdef ERR_INJECT_EN
  logic        err_inject = 1'b0;
  logic [15:0] a_err_cnt, b_err_cnt;
`endif

  ofdm_bit_source #(.PAT_W(4), .LFSR_W(7), .LFSR_TAPS(7'h60), .FRAME_LEN(FL), .GAP_LEN(0)) dut_a (
    .clk(clk), .reset(reset), .enable_i(enable), .mode_i(mode), .pattern_i(pattern), .seed_i(seed),
    .bit_out_o(a_bit), .bit_valid_o(a_valid), .bit_ready_i(ready), .sof_o(a_sof), .eof_o(a_eof),
    .frame_cnt_o(a_fc), .busy_o(a_busy)
`ifdef ERR_INJECT_EN
    , .err_inject_i(err_inject), .err_cnt_o(a_err_cnt)
`endif
  );

  ofdm_bit_source #(.PAT_W(4), .LFSR_W(7), .LFSR_TAPS(7'h60), .FRAME_LEN(FL), .GAP_LEN(2)) dut_b (
    .clk(clk), .reset(reset), .enable_i(enable), .mode_i(mode), .pattern_i(pattern), .seed_i(seed),
    .bit_out_o(b_bit), .bit_valid_o(b_valid), .bit_ready_i(ready), .sof_o(b_sof), .eof_o(b_eof),
    .frame_cnt_o(b_fc), .busy_o(b_busy)
`ifdef ERR_INJECT_EN
    , .err_inject_i(err_inject), .err_cnt_o(b_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        b;
    logic        sof;
    logic        eof;
    logic [15:0] fc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  int          pos = 0;
  logic [15:0] exp_fc = 16'd0;
  int          cyc = 0;
  bit          gap_run = 1'b0;
  int          gcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push(input logic b);
    exp_t e;
    e.b   = b;
    e.sof = (pos == 0);
    e.eof = (pos == FL - 1);
    e.fc  = exp_fc;
    if (e.eof) exp_fc++;
    pos = (pos + 1) % FL;
    q.push_back(e);
  endtask

  // v is listed first-bit-in-bit-0
  task automatic push_vec(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) push(v[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_qsize(input int n, input int budget);
    int k = 0;
    while (q.size() > n && k < budget) begin tick(); k++; end
    if (q.size() > n) begin
      checks++;
      $display("FAIL wait_qsize: %0d pending, required <= %0d", q.size(), n);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin tick(); k++; end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected transfers not seen, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((a_busy || b_busy) && k < budget) begin tick(); k++; end
    if (a_busy || b_busy) begin
      checks++;
      $display("FAIL wait_idle: busy a=%0b b=%0b, required 0", a_busy, b_busy);
    end
  endtask

  task automatic push_prbs_from_ones(input int n);
    logic [6:0] l;
    l = 7'h7F;
    push_vec(64'h7F, 8);
    for (int i = 0; i < n; i++) begin
      if (i >= 8) push(l[6]);
      l = {l[5:0], ^(l & 7'h60)};
    end
  endtask

  // scoreboard monitor for dut_a
  always @(negedge clk) begin
    exp_t e;
    if (!reset && a_valid && ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL transfer: got unexpected bit %0b, required no transfer", a_bit);
      end else begin
        e = q.pop_front();
        chk("bit_out", a_bit, e.b);
        chk("sof", a_sof, e.sof);
        chk("eof", a_eof, e.eof);
        chk("frame_cnt", a_fc, e.fc);
      end
    end
  end

  // gap monitor for dut_b
  always @(negedge clk) begin
    if (reset) begin
      gap_run = 1'b0;
    end else if (gap_run) begin
      if (b_valid) begin
        chk("gap_len_before_sof", gcnt, 2);
        chk("gap_sof", b_sof, 1);
        gap_run = 1'b0;
      end else if (b_busy) begin
        gcnt++;
      end else begin
        chk("gap_len_before_idle", gcnt, 2);
        gap_run = 1'b0;
      end
    end else if (b_valid && ready && b_eof) begin
      gap_run = 1'b1;
      gcnt = 0;
    end
  end

  initial begin
    int c0;
    repeat (3) tick();
    chk("rst_bit_out", a_bit, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_sof", a_sof, 0);
    chk("rst_eof", a_eof, 0);
    chk("rst_frame_cnt", a_fc, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_busy", b_busy, 0);
    reset = 1'b0;
    tick();

    // reset at bit 5 of the first frame, then a clean restart
    mode = 2'b00; pattern = 4'b0110;
    push_vec(64'h06, 5);
    start_frame();
    drain(50);
    chk("bit5_presented", a_bit, 1);
    reset = 1'b1;
    tick();
    chk("midrst_bit_out", a_bit, 0);
    chk("midrst_valid", a_valid, 0);
    chk("midrst_eof", a_eof, 0);
    chk("midrst_frame_cnt", a_fc, 0);
    chk("midrst_busy", a_busy, 0);
    reset = 1'b0;
    pos = 0; exp_fc = 16'd0;
    tick();
    push_vec(64'h66, 8);
    start_frame();
    drain(50);
    wait_idle(50);

    // pattern 0110, two back-to-back frames, 1-cycle start latency
    push_vec(64'h6666, 16);
    enable = 1'b1;
    #3;
    chk("start_latency_low", a_valid, 0);
    tick();
    chk("start_latency_high", a_valid, 1);
    c0 = cyc;
    wait_qsize(4, 50);
    enable = 1'b0;
    drain(50);
    chk("back_to_back_cycles", cyc - c0, 16);
    wait_idle(50);
    chk("frame_cnt_idle", a_fc, exp_fc);

    // PRBS from 7F, then seed 0 must give identical bits
    for (int s = 0; s < 2; s++) begin
      mode = 2'b01; seed = (s == 0) ? 7'h7F : 7'h00;
      push_prbs_from_ones(136);
      enable = 1'b1;
      wait_qsize(4, 400);
      enable = 1'b0;
      drain(50);
      wait_idle(100);
    end

    // alternating and all-zero
    mode = 2'b11;
    push_vec(64'hAA, 8);
    start_frame();
    drain(50);
    wait_idle(50);
    mode = 2'b10;
    push_vec(64'h00, 8);
    start_frame();
    drain(50);
    wait_idle(50);

    // backpressure: 3 stalled cycles with bit 3 presented
    mode = 2'b00; pattern = 4'b1011;
    push_vec(64'hBB, 8);
    start_frame();
    wait_qsize(5, 50);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", a_valid, 1);
      chk("stall_bit_out", a_bit, q[0].b);
      chk("stall_sof", a_sof, q[0].sof);
      chk("stall_eof", a_eof, q[0].eof);
      tick();
    end
    chk("stall_pending", q.size(), 5);
    ready = 1'b1;
    drain(50);
    wait_idle(50);

`ifdef ERR_INJECT_EN
    // two pulses while idle collapse into one inverted first bit
    mode = 2'b00; pattern = 4'b0000;
    err_inject = 1'b1;
    tick();
    tick();
    err_inject = 1'b0;
    push_vec(64'h01, 8);
    start_frame();
    drain(50);
    wait_idle(50);
    chk("err_cnt", a_err_cnt, 1);
`endif

    chk("final_frame_cnt", a_fc, exp_fc);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
